leds_ram_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter that shares the single-port 5120x32 on-chip program/data RAM between two requesters, e.g. the Nios II data master and a DMA or debug master.
- Sits between the masters and the RAM's s1 slave port.
- Grants one access per cycle using round-robin fairness.
- Tracks the RAM's fixed 1-cycle read latency and returns read data to the master that issued the read.
- Adds address range checking and a freeze/hold input.

---
 rtl/leds_ram_arbiter.sv | 74 +++++++
 tb/tb_leds_ram_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/leds_ram_arbiter.sv
// leds_ram_arbiter: round-robin two-master Avalon-MM arbiter for the shared single-port on-chip RAM
module leds_ram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata
);
  logic              w_m0_req, w_m1_req, w_g0, w_g1, w_any, w_oor, w_rd, w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic              r_last_grant, r_rd_pend, r_rd_id, r_rd_oor;
  // Grant decision: a lone requester wins, contention goes to the master that did not win last
  always_comb begin
    w_m0_req = m0_read | m0_write;
    w_m1_req = m1_read | m1_write;
    w_g0     = !reset && !freeze && w_m0_req && (!w_m1_req || r_last_grant);
    w_g1     = !reset && !freeze && w_m1_req && (!w_m0_req || !r_last_grant);
    w_any    = w_g0 | w_g1;
    w_addr   = w_g1 ? m1_address : m0_address;
    w_oor    = 32'(w_addr) >= DEPTH;
    w_wr     = w_g1 ? m1_write : m0_write;
    w_rd     = (w_g1 ? m1_read : m0_read) & !w_wr;
  end
  assign m0_waitrequest   = !w_g0;
  assign m1_waitrequest   = !w_g1;
  assign ram_address      = w_any ? w_addr : '0;
  assign ram_byteenable   = w_any ? (w_g1 ? m1_byteenable : m0_byteenable) : 4'd0;
  assign ram_writedata    = w_any ? (w_g1 ? m1_writedata : m0_writedata) : 32'd0;
  assign ram_chipselect   = w_any & !w_oor;
  assign ram_write        = w_any & !w_oor & w_wr;
  assign ram_clken        = 1'b1;
  assign m0_readdatavalid = r_rd_pend & !r_rd_id;
  assign m1_readdatavalid = r_rd_pend & r_rd_id;
  assign m0_readdata      = (m0_readdatavalid && !r_rd_oor) ? ram_readdata : 32'd0;
  assign m1_readdata      = (m1_readdatavalid && !r_rd_oor) ? ram_readdata : 32'd0;
  // Round-robin history and the one-cycle read return tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_id      <= 1'b0;
      r_rd_oor     <= 1'b0;
    end else begin
      if (w_any) r_last_grant <= w_g1;
      r_rd_pend <= w_any & w_rd;
      r_rd_id   <= w_g1;
      r_rd_oor  <= w_oor;
    end
  end
endmodule

// File: tb/tb_leds_ram_arbiter.sv
// tb_leds_ram_arbiter: scoreboard bench for the two-master RAM arbiter
module tb_leds_ram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5120;
  logic              clk = 0, reset = 1, freeze = 0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [3:0]        m0_byteenable = 4'hf, m1_byteenable = 4'hf;
  logic              m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0]       m0_writedata = '0, m1_writedata = '0;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]       m0_readdata, m1_readdata;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [31:0]       ram_writedata, ram_readdata = '0;
  int                n_chk = 0, n_err = 0;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       shadow [DEPTH];
  typedef struct {bit id; logic [31:0] data;} exp_t;
  exp_t              q[$];
  leds_ram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );
  always #5 clk = ~clk;
  // RAM model: synchronous read, byte-lane writes, address wraps modulo depth
  always @(posedge clk) begin
    int ia;
    ia = int'(ram_address) % DEPTH;
    if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ia][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      ram_readdata <= mem[ia];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_reset_vals();
    check("rst_wr0", 32'(m0_waitrequest), 1);
    check("rst_wr1", 32'(m1_waitrequest), 1);
    check("rst_rv0", 32'(m0_readdatavalid), 0);
    check("rst_rv1", 32'(m1_readdatavalid), 0);
    check("rst_rd0", m0_readdata, 0);
    check("rst_rd1", m1_readdata, 0);
    check("rst_ra", 32'(ram_address), 0);
    check("rst_be", 32'(ram_byteenable), 0);
    check("rst_cs", 32'(ram_chipselect), 0);
    check("rst_we", 32'(ram_write), 0);
    check("rst_wd", ram_writedata, 0);
    check("rst_ck", 32'(ram_clken), 1);
  endtask
  // One cycle: inputs already driven; g is the expected winner (0 none, 1 m0, 2 m1)
  task automatic step(input int g);
    logic [ADDR_W-1:0] a;
    logic              r, w, oor;
    logic [3:0]        be;
    logic [31:0]       d;
    exp_t              e;
    #4;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rv0", 32'(m0_readdatavalid), 32'(e.id == 0));
      check("rv1", 32'(m1_readdatavalid), 32'(e.id == 1));
      check(e.id ? "rdata1" : "rdata0", e.id ? m1_readdata : m0_readdata, e.data);
      check("rdata_other", e.id ? m0_readdata : m1_readdata, 0);
    end else begin
      check("rv0_idle", 32'(m0_readdatavalid), 0);
      check("rv1_idle", 32'(m1_readdatavalid), 0);
      check("rd_idle", m0_readdata | m1_readdata, 0);
    end
    check("wr0", 32'(m0_waitrequest), 32'(g != 1));
    check("wr1", 32'(m1_waitrequest), 32'(g != 2));
    a   = (g == 2) ? m1_address : m0_address;
    r   = (g == 2) ? m1_read : m0_read;
    w   = (g == 2) ? m1_write : m0_write;
    be  = (g == 2) ? m1_byteenable : m0_byteenable;
    d   = (g == 2) ? m1_writedata : m0_writedata;
    oor = int'(a) >= DEPTH;
    check("cs", 32'(ram_chipselect), 32'(g != 0 && !oor));
    check("we", 32'(ram_write), 32'(g != 0 && w && !oor));
    check("clken", 32'(ram_clken), 1);
    if (g != 0 && !oor) begin
      check("ra", 32'(ram_address), 32'(a));
      if (w) begin
        check("wd", ram_writedata, d);
        check("be", 32'(ram_byteenable), 32'(be));
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    if (g != 0 && r && !w) begin
      e.id   = (g == 2);
      e.data = oor ? 32'd0 : shadow[a];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    m0_read = 1;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    m0_read = 0;
    reset = 0;
    // simultaneous writes: m0 first, m1 the next cycle
    m0_write = 1; m0_address = 13'h10; m0_writedata = 32'hDEADBEEF;
    m1_write = 1; m1_address = 13'h11; m1_writedata = 32'h12345678;
    step(1);
    m0_write = 0;
    step(2);
    idle_all();
    m0_read = 1; m0_address = 13'h10;
    step(1);
    m0_read = 0; m1_read = 1; m1_address = 13'h11;
    step(2);
    // continuous read contention alternates masters
    m0_read = 1; m0_address = 13'h11; m1_address = 13'h10;
    for (int i = 0; i < 8; i++) step(i % 2 == 0 ? 1 : 2);
    idle_all();
    step(0);
    // partial byte-lane write
    m0_write = 1; m0_address = 13'h20; m0_writedata = 32'hAABBCCDD; m0_byteenable = 4'b0010;
    step(1);
    m0_write = 0; m0_byteenable = 4'hf; m0_read = 1;
    step(1);
    m0_read = 0;
    step(0);
    check("be_shadow", shadow[32], 32'h0000CC00);
    // out-of-range write and read
    m1_write = 1; m1_address = 13'd0; m1_writedata = 32'h55AA55AA;
    step(2);
    m1_address = 13'd5120; m1_writedata = 32'h11111111;
    step(2);
    m1_write = 0; m1_read = 1;
    step(2);
    m1_address = 13'd0;
    step(2);
    m1_read = 0;
    step(0);
    check("oor_mem0", mem[0], 32'h55AA55AA);
    // freeze: prior read returns, held request waits, grant after release
    m0_read = 1; m0_address = 13'h10;
    step(1);
    freeze = 1; m0_address = 13'h11;
    repeat (3) step(0);
    freeze = 0;
    step(1);
    // write granted while a read's data returns
    m0_read = 0; m1_read = 1; m1_address = 13'h20;
    step(2);
    m1_read = 0; m0_write = 1; m0_address = 13'h30; m0_writedata = 32'hCAFEF00D;
    step(1);
    m0_write = 0; m0_read = 1;
    step(1);
    // reset arriving while a read is in flight discards it
    m0_address = 13'h10;
    step(1);
    m1_read = 1;
    reset = 1;
    q.delete();
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 0;
    step(1);
    m0_read = 0;
    step(2);
    m1_read = 0;
    step(0);
    step(0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
